duty_meter: RTL

//  Measures the high time and low time of a periodic waveform, in clk cycles.

---
 rtl/duty_meter_if.sv | 33 +++
 rtl/duty_meter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/duty_meter_if.sv
// Signal bundle for duty_meter: measured waveform and enable in, recovered on/off times out.
// W must match the W of the duty_meter instance it is bound to.
interface duty_meter_if #(
  parameter int unsigned W = 8
) ();
  logic         sig_in;
  logic         en;
  logic [W-1:0] on_time;
  logic [W-1:0] off_time;
  logic         valid;
  logic         sat;
  logic         stuck;

  modport master (
    output sig_in,
    output en,
    input  on_time,
    input  off_time,
    input  valid,
    input  sat,
    input  stuck
  );

  modport slave (
    input  sig_in,
    input  en,
    output on_time,
    output off_time,
    output valid,
    output sat,
    output stuck
  );
endinterface

// File: rtl/duty_meter.sv
// Recovers the high/low times (in clk cycles) of an asynchronous periodic waveform.
// Optional stuck-level detector compiled in when DUTY_METER_STUCK_EN is defined.
module duty_meter #(
  parameter int unsigned W           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STUCK_LIMIT = 255
) (
  input logic          clk,
  input logic          rst,
  duty_meter_if.slave  bus
);

  if (SYNC_STAGES < 2 || STUCK_LIMIT > (2 ** W) - 1) begin : gen_bad_params
    $error("duty_meter: SYNC_STAGES must be >= 2 and STUCK_LIMIT <= 2**W-1");
  end

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [W-1:0] CntMax = {W{1'b1}};
  localparam logic [W-1:0] CntOne = W'(1);

  // Synchroniser and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev_q;
  logic                   rise;
  logic                   fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_prev_q <= s;
    end
  end

  // Measurement FSM and result registers
  state_e         state_q, state_d;
  logic [W-1:0]   hcnt_q, hcnt_d;
  logic [W-1:0]   lcnt_q, lcnt_d;
  logic           sat_flag_q, sat_flag_d;
  logic [W-1:0]   on_q, on_d;
  logic [W-1:0]   off_q, off_d;
  logic           sat_q, sat_d;
  logic           valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      sat_flag_q <= 1'b0;
      on_q       <= '0;
      off_q      <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      sat_flag_q <= sat_flag_d;
      on_q       <= on_d;
      off_q      <= off_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    sat_flag_d = sat_flag_q;
    on_d       = on_q;
    off_d      = off_q;
    sat_d      = sat_q;
    valid_d    = 1'b0;

    if (!bus.en) begin
      // Abort: results hold, the next measurement starts at a fresh rise.
      state_d    = StIdle;
      hcnt_d     = '0;
      lcnt_d     = '0;
      sat_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d    = StHigh;
            hcnt_d     = CntOne;
            lcnt_d     = '0;
            sat_flag_d = 1'b0;
          end
        end
        StHigh: begin
          if (fall) begin
            state_d = StLow;
            lcnt_d  = CntOne;
          end else if (hcnt_q == CntMax) begin
            sat_flag_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + CntOne;
          end
        end
        StLow: begin
          if (rise) begin
            on_d       = hcnt_q;
            off_d      = lcnt_q;
            sat_d      = sat_flag_q;
            valid_d    = 1'b1;
            state_d    = StHigh;
            hcnt_d     = CntOne;
            lcnt_d     = '0;
            sat_flag_d = 1'b0;
          end else if (lcnt_q == CntMax) begin
            sat_flag_d = 1'b1;
          end else begin
            lcnt_d = lcnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign bus.on_time  = on_q;
  assign bus.off_time = off_q;
  assign bus.valid    = valid_q;
  assign bus.sat      = sat_q;

`ifdef DUTY_METER_STUCK_EN
  localparam logic [W-1:0] StuckLim = W'(STUCK_LIMIT);

  logic stuck_q, stuck_d;

  // Compares the post-edge count so the flag rises on the same edge the limit is reached.
  always_comb begin
    stuck_d = stuck_q;
    if (!bus.en || rise || fall) begin
      stuck_d = 1'b0;
    end else if (state_q == StHigh && hcnt_d >= StuckLim) begin
      stuck_d = 1'b1;
    end else if (state_q == StLow && lcnt_d >= StuckLim) begin
      stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stuck_q <= 1'b0;
    end else begin
      stuck_q <= stuck_d;
    end
  end

  assign bus.stuck = stuck_q;
`else
  assign bus.stuck = 1'b0;
`endif

endmodule
